dac_serial_rx: RTL and testbench

- Receiver end of the 3-wire DAC serial link: word clock, bit clock, data; 16-bit words sent MSB first.
- Oversamples the link on the local `bitclk` and rebuilds each word.
- Presents each word in a single-entry hold register with valid/ack handshake.
- Used as loopback checker and as front end for external ADC boards that share the same framing.

---
 rtl/dac_serial_rx.sv | 218 +++++++++++++++++++++
 tb/tb_dac_serial_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_rx.sv
// Receiver for the 3-wire DAC serial link (word clock, bit clock, data), MSB first.
// Optional partial-frame abort on a stalled bit clock: define DAC_RX_TIMEOUT_EN.
module dac_serial_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic             bitclk,
  input  logic             rst,
  input  logic             sbclk,
  input  logic             swclk,
  input  logic             sdin,
  output logic [WIDTH-1:0] rx_word,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr,
  output logic             rx_busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  if (SYNC_STAGES < 2 || WIDTH < 2 || TIMEOUT < 2) begin : g_bad_params
    $error("dac_serial_rx: SYNC_STAGES, WIDTH and TIMEOUT must all be at least 2");
  end

  state_t           state;
  state_t           state_next;

  logic [SYNC_STAGES-1:0] sb_sync;
  logic [SYNC_STAGES-1:0] sw_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic             sb_prev;
  logic             sb_s;
  logic             sw_s;
  logic             sd_s;
  logic             bit_edge;
  logic             start;
  logic             armed;

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] count;
  logic             last_bit;
  logic             tmo_hit;

  logic             do_restart;
  logic             do_shift;
  logic             do_load;
  logic             do_drop;
  logic             do_abort;
  logic             set_ferr;

  // Input synchronisers and bit-clock rising-edge detect
  always_ff @(posedge bitclk) begin
    if (rst) begin
      sb_sync <= '0;
      sw_sync <= '0;
      sd_sync <= '0;
      sb_prev <= 1'b0;
    end else begin
      sb_sync <= {sb_sync[SYNC_STAGES-2:0], sbclk};
      sw_sync <= {sw_sync[SYNC_STAGES-2:0], swclk};
      sd_sync <= {sd_sync[SYNC_STAGES-2:0], sdin};
      sb_prev <= sb_sync[SYNC_STAGES-1];
    end
  end

  assign sb_s     = sb_sync[SYNC_STAGES-1];
  assign sw_s     = sw_sync[SYNC_STAGES-1];
  assign sd_s     = sd_sync[SYNC_STAGES-1];
  assign bit_edge = sb_s & ~sb_prev;
  assign start    = bit_edge & ~sw_s & armed;
  assign last_bit = (count == CNT_W'(WIDTH - 1));

  // A start needs swclk to have been seen high since the previous start
  always_ff @(posedge bitclk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (start || do_abort) begin
      armed <= 1'b0;
    end else if (bit_edge && sw_s) begin
      armed <= 1'b1;
    end
  end

`ifdef DAC_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts bitclk cycles since the last bit edge of the current frame
  always_ff @(posedge bitclk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state != SHIFT || bit_edge) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (state == SHIFT) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge bitclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          state_next = SHIFT;
        end else if (bit_edge && last_bit) begin
          state_next = DONE;
        end else if (tmo_hit) begin
          state_next = IDLE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    do_restart = 1'b0;
    do_shift   = 1'b0;
    do_load    = 1'b0;
    do_drop    = 1'b0;
    do_abort   = 1'b0;
    set_ferr   = 1'b0;
    case (state)
      IDLE: begin
        do_restart = start;
      end
      SHIFT: begin
        if (start) begin
          do_restart = 1'b1;
          set_ferr   = 1'b1;
        end else if (bit_edge) begin
          do_shift = 1'b1;
        end else if (tmo_hit) begin
          do_abort = 1'b1;
          set_ferr = 1'b1;
        end
      end
      DONE: begin
        // A same-cycle ack frees the holding register, so the new word loads
        if (!rx_valid || rx_ack) begin
          do_load = 1'b1;
        end else begin
          do_drop = 1'b1;
        end
      end
      default: begin
        do_abort = 1'b0;
      end
    endcase
  end

  always_ff @(posedge bitclk) begin
    if (rst) begin
      shreg     <= '0;
      count     <= '0;
      rx_word   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      if (do_restart) begin
        shreg <= {{(WIDTH-1){1'b0}}, sd_s};
        count <= CNT_W'(1);
      end else if (do_shift) begin
        shreg <= {shreg[WIDTH-2:0], sd_s};
        count <= count + CNT_W'(1);
      end else if (do_load || do_drop || do_abort) begin
        count <= '0;
      end

      if (do_load) begin
        rx_word  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      // Sticky flags: a new error event beats a simultaneous clear
      overrun   <= do_drop  | (overrun   & ~err_clr);
      frame_err <= set_ferr | (frame_err & ~err_clr);
      rx_busy   <= (state_next == SHIFT);
    end
  end

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed and randomized bench for dac_serial_rx against a bit-level framing model.
module tb_dac_serial_rx;

  localparam int unsigned W = 16;

  logic         bitclk;
  logic         rst;
  logic         sbclk;
  logic         swclk;
  logic         sdin;
  logic [W-1:0] rx_word;
  logic         rx_valid;
  logic         rx_ack;
  logic         overrun;
  logic         frame_err;
  logic         err_clr;
  logic         rx_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_armed;
  bit          m_in;
  bit          m_q[$];
  logic [W-1:0] m_word;
  bit          m_valid;
  bit          m_ovr;
  bit          m_ferr;

  dac_serial_rx #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(64)) dut (
    .bitclk   (bitclk),
    .rst      (rst),
    .sbclk    (sbclk),
    .swclk    (swclk),
    .sdin     (sdin),
    .rx_word  (rx_word),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .overrun  (overrun),
    .frame_err(frame_err),
    .err_clr  (err_clr),
    .rx_busy  (rx_busy)
  );

  initial bitclk = 1'b0;
  always #5 bitclk = ~bitclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_in = 0; m_q.delete();
    m_word = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;
  endtask

  // One serial bit as the link rules see it; ack=1 means a consumer ack coincides with completion
  task automatic model_bit(input bit b, input bit w, input bit ack);
    int unsigned v;
    if (m_armed && !w) begin
      if (m_in) m_ferr = 1;
      m_q.delete();
      m_q.push_back(b);
      m_in = 1;
      m_armed = 0;
    end else begin
      if (w) m_armed = 1;
      if (m_in) m_q.push_back(b);
    end
    if (m_in && m_q.size() == W) begin
      v = 0;
      foreach (m_q[i]) v = v * 2 + int'(m_q[i]);
      if (!m_valid || ack) begin
        m_word  = W'(v);
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
      m_in = 0;
      m_q.delete();
    end
  endtask

  task automatic send_bit(input bit b, input bit w);
    @(negedge bitclk);
    sbclk = 1'b0; swclk = w; sdin = b;
    repeat (4) @(negedge bitclk);
    sbclk = 1'b1;
    repeat (4) @(negedge bitclk);
    model_bit(b, w, 1'b0);
  endtask

  // mode 0: plain; 1: check valid latency on last bit; 2: ack during the completion cycle
  task automatic send_frame(input logic [W-1:0] word, input int mode);
    bit b, w;
    for (int i = W - 1; i >= 0; i--) begin
      b = word[i];
      w = (i < W / 2);
      if (i == 0 && mode != 0) begin
        @(negedge bitclk);
        sbclk = 1'b0; swclk = w; sdin = b;
        repeat (4) @(negedge bitclk);
        sbclk = 1'b1;
        repeat (3) @(posedge bitclk);
        #1;
        if (mode == 1) check("latency_pre", 32'(rx_valid), 32'd0);
        else rx_ack = 1'b1;
        @(posedge bitclk);
        #1;
        rx_ack = 1'b0;
        model_bit(b, w, mode == 2);
        if (mode == 1) check("latency_valid", 32'(rx_valid), 32'd1);
        repeat (3) @(negedge bitclk);
      end else begin
        send_bit(b, w);
      end
    end
  endtask

  task automatic check_all(input string tag);
    repeat (6) @(negedge bitclk);
    check($sformatf("%s.word", tag),      32'(rx_word),   32'(m_word));
    check($sformatf("%s.valid", tag),     32'(rx_valid),  32'(m_valid));
    check($sformatf("%s.overrun", tag),   32'(overrun),   32'(m_ovr));
    check($sformatf("%s.frame_err", tag), 32'(frame_err), 32'(m_ferr));
    check($sformatf("%s.busy", tag),      32'(rx_busy),   32'(m_in));
  endtask

  task automatic do_ack();
    @(negedge bitclk); rx_ack = 1'b1;
    @(negedge bitclk); rx_ack = 1'b0;
    m_valid = 0;
  endtask

  task automatic do_clr();
    @(negedge bitclk); err_clr = 1'b1;
    @(negedge bitclk); err_clr = 1'b0;
    m_ovr = 0; m_ferr = 0;
  endtask

  task automatic do_reset();
    @(negedge bitclk); sbclk = 1'b0;
    repeat (4) @(negedge bitclk);
    rst = 1'b1;
    repeat (2) @(negedge bitclk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [W-1:0] word;
    int k;
    rst = 1'b1; sbclk = 1'b0; swclk = 1'b0; sdin = 1'b0;
    rx_ack = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge bitclk);
    rst = 1'b0;
    check("reset.word",      32'(rx_word),   32'd0);
    check("reset.valid",     32'(rx_valid),  32'd0);
    check("reset.overrun",   32'(overrun),   32'd0);
    check("reset.frame_err", 32'(frame_err), 32'd0);
    check("reset.busy",      32'(rx_busy),   32'd0);

    // First frame after arming, with valid latency check
    send_bit(1'($urandom_range(1)), 1'b1);
    send_bit(1'($urandom_range(1)), 1'b1);
    send_frame(16'hA5C3, 1);
    check_all("a5c3");
    do_ack();

    // Back-to-back frames, each acked
    send_frame(16'h0001, 0);
    check_all("b2b0");
    do_ack();
    send_frame(16'hFFFF, 0);
    check_all("b2b1");
    do_ack();
    check_all("b2b_acked");

    // Overrun, clear, ack
    send_frame(16'h1234, 0);
    check_all("ovr0");
    send_frame(16'h5678, 0);
    check_all("ovr1");
    do_clr();
    check_all("ovr_clr");
    do_ack();
    check_all("ovr_ack");

    // Ack coinciding with the completion cycle: the new word loads
    send_frame(16'($urandom), 0);
    check_all("ackdone0");
    send_frame(16'($urandom), 2);
    check_all("ackdone1");
    do_ack();

    // Restart after 5 bits
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1)), 1'b0);
    send_bit(1'($urandom_range(1)), 1'b1);
    send_frame(16'hBEEF, 0);
    check_all("restart");
    do_clr();
    do_ack();

    // Reset mid-frame; nothing starts until swclk is seen high
    word = 16'h8001;
    for (int i = W - 1; i >= W - 9; i--) send_bit(word[i], i < W / 2);
    do_reset();
    check_all("midrst");
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(1)), 1'b0);
    check_all("unarmed");
    send_bit(1'($urandom_range(1)), 1'b1);
    send_bit(1'($urandom_range(1)), 1'b1);
    send_frame(16'h7FFE, 0);
    check_all("after_rst");
    do_ack();

`ifdef DAC_RX_TIMEOUT_EN
    word = 16'($urandom);
    for (int i = W - 1; i >= W - 10; i--) send_bit(word[i], i < W / 2);
    repeat (55) @(negedge bitclk);
    check("tmo_pre.busy", 32'(rx_busy), 32'd1);
    check("tmo_pre.frame_err", 32'(frame_err), 32'd0);
    repeat (12) @(negedge bitclk);
    m_ferr = 1; m_in = 0; m_armed = 0; m_q.delete();
    check_all("timeout");
    do_clr();
`endif

    send_bit(1'($urandom_range(1)), 1'b1);

    // Randomized frames with occasional broken frames, acks and clears
    for (int it = 0; it < 12; it++) begin
      word = 16'($urandom);
      if ($urandom_range(3) == 0) begin
        k = int'($urandom_range(7, 1));
        for (int j = 0; j < k; j++) send_bit(1'($urandom_range(1)), 1'b0);
        send_bit(1'($urandom_range(1)), 1'b1);
      end
      send_frame(word, 0);
      check_all($sformatf("rnd%0d", it));
      if ($urandom_range(1) == 1) do_ack();
      if ($urandom_range(3) == 0) do_clr();
    end
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
